// File: rtl/vram_scan_reader.sv
// vram_scan_reader: framebuffer scan-out engine for the video read port of the shared
// dual-port RAM. It walks LINES x LINE_BYTES bytes from BASE_ADDR and absorbs the port's
// fixed read latency. Returned bytes are buffered in a show-ahead FIFO and streamed out
// with start-of-frame / end-of-line tags.
//
// Ports:
//   clk_i          block clock, also the RAM read-port clock
//   reset_i        synchronous active-high reset
//   frame_start_i  one-cycle pulse that (re)starts a frame fetch
//   rd_addr_o      registered RAM read address
//   rd_data_i      RAM read data, READ_LATENCY cycles after the address
//   pix_data_o     stream byte (FIFO head)
//   pix_valid_o    FIFO non-empty
//   pix_ready_i    consumer accepts on valid & ready
//   pix_sof_o      head byte is byte 0 of the frame
//   pix_eol_o      head byte is the last byte of a line
//   busy_o         fetching, reads in flight, or FIFO non-empty
//   underrun_o     consumer ready with no data while fetching
module vram_scan_reader #(
  parameter logic [15:0] BASE_ADDR    = 16'h8000,
  parameter int unsigned LINE_BYTES   = 40,
  parameter int unsigned LINES        = 240,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        frame_start_i,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i,
  output logic [7:0]  pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic        pix_sof_o,
  output logic        pix_eol_o,
  output logic        busy_o,
  output logic        underrun_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned Rl   = READ_LATENCY;

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      byte_q, byte_d;
  logic [7:0]      line_q, line_d;
  logic [Rl-1:0]   vld_q, vld_d;
  logic [Rl-1:0]   sof_q, sof_d;
  logic [Rl-1:0]   eol_q, eol_d;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;

  logic            issue, is_sof, is_eol, is_last;
  logic            push, pop, nempty;
  logic [9:0]      head;
  int unsigned     inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < Rl; i++) begin
      inflight += 32'(vld_q[i]);
    end
  end

  always_comb begin
    is_eol  = (byte_q == 8'(LINE_BYTES - 1));
    is_sof  = (byte_q == 8'd0) && (line_q == 8'd0);
    is_last = is_eol && (line_q == 8'(LINES - 1));
    // Credit check counts in-flight reads so returns can never overflow the FIFO.
    issue   = (state_q == StFetch) && !frame_start_i &&
              ((32'(cnt_q) + inflight) < FIFO_DEPTH);

    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    line_d  = line_q;
    if (frame_start_i) begin
      state_d = StFetch;
      addr_d  = BASE_ADDR;
      byte_d  = 8'd0;
      line_d  = 8'd0;
    end else if (issue) begin
      // rd_addr shows the issued address; after the last issue it parks there.
      if (is_last) begin
        state_d = StDone;
      end else begin
        addr_d = addr_q + 16'd1;
      end
      if (is_eol) begin
        byte_d = 8'd0;
        line_d = line_q + 8'd1;
      end else begin
        byte_d = byte_q + 8'd1;
      end
    end

    vld_d[0] = issue;
    sof_d[0] = is_sof;
    eol_d[0] = is_eol;
    for (int i = 1; i < Rl; i++) begin
      vld_d[i] = vld_q[i-1];
      sof_d[i] = sof_q[i-1];
      eol_d[i] = eol_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      addr_q  <= BASE_ADDR;
      byte_q  <= 8'd0;
      line_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
    end
  end

  // A restart discards every outstanding return along with the buffered bytes.
  always_ff @(posedge clk_i) begin
    if (reset_i || frame_start_i) begin
      vld_q <= '0;
      sof_q <= '0;
      eol_q <= '0;
    end else begin
      vld_q <= vld_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
    end
  end

  assign push   = vld_q[Rl-1];
  assign nempty = (cnt_q != '0);
  assign pop    = nempty && pix_ready_i;
  assign head   = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= {eol_q[Rl-1], sof_q[Rl-1], rd_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || frame_start_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    rd_addr_o   = addr_q;
    pix_valid_o = nempty;
    // Stale storage is hidden while empty so the outputs read as zero.
    pix_data_o  = nempty ? head[7:0] : 8'h00;
    pix_sof_o   = nempty && head[8];
    pix_eol_o   = nempty && head[9];
    busy_o      = (state_q == StFetch) || (inflight != 0) || nempty;
    underrun_o  = pix_ready_i && !nempty && (state_q == StFetch);
  end

endmodule

// File: tb/tb_vram_scan_reader.sv
// Directed bench for vram_scan_reader: basic frame, underrun, backpressure, restart,
// address wrap (second instance) and reset mid-frame. Inputs change on the falling edge;
// outputs are checked 1 ns later.
module tb_vram_scan_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, fs, rdy, fs_w, rdy_w;
  logic [15:0] addr, addr_w;
  logic [7:0]  rdata, rdata_w, pdata, pdata_w;
  logic        pv, psof, peol, busy, und;
  logic        pv_w, psof_w, peol_w, busy_w, und_w;
  logic [7:0]  m1, m2, w1, w2;

  int vectors = 0;
  int errors  = 0;

  // RAM models: return addr[7:0] two cycles after the address.
  always @(posedge clk) begin
    m1 <= addr[7:0];
    m2 <= m1;
    w1 <= addr_w[7:0];
    w2 <= w1;
  end
  assign rdata   = m2;
  assign rdata_w = w2;

  vram_scan_reader #(
    .BASE_ADDR(16'h0010), .LINE_BYTES(4), .LINES(2), .READ_LATENCY(2), .FIFO_DEPTH(8)
  ) u_dut (
    .clk_i(clk), .reset_i(reset), .frame_start_i(fs), .rd_addr_o(addr), .rd_data_i(rdata),
    .pix_data_o(pdata), .pix_valid_o(pv), .pix_ready_i(rdy), .pix_sof_o(psof),
    .pix_eol_o(peol), .busy_o(busy), .underrun_o(und)
  );

  vram_scan_reader #(
    .BASE_ADDR(16'hFFFE), .LINE_BYTES(4), .LINES(1), .READ_LATENCY(2), .FIFO_DEPTH(8)
  ) u_wrap (
    .clk_i(clk), .reset_i(reset), .frame_start_i(fs_w), .rd_addr_o(addr_w),
    .rd_data_i(rdata_w), .pix_data_o(pdata_w), .pix_valid_o(pv_w), .pix_ready_i(rdy_w),
    .pix_sof_o(psof_w), .pix_eol_o(peol_w), .busy_o(busy_w), .underrun_o(und_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] a;
    reset = 1'b1; fs = 1'b0; rdy = 1'b0; fs_w = 1'b0; rdy_w = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_addr", addr, 16'h0010);
    chk("rst_valid", pv, 0);
    chk("rst_data", pdata, 8'h00);
    chk("rst_sof", psof, 0);
    chk("rst_eol", peol, 0);
    chk("rst_busy", busy, 0);
    chk("rst_under", und, 0);
    chk("rst_addr_w", addr_w, 16'hFFFE);

    // Basic frame with ready high; underrun for the latency window only.
    @(negedge clk); fs = 1'b1; rdy = 1'b1; #1;
    chk("idle_under", und, 0);
    @(negedge clk); fs = 1'b0; #1;
    chk("b_addr0", addr, 16'h0010);
    chk("b_under1", und, 1);
    chk("b_busy", busy, 1);
    chk("b_nvalid", pv, 0);
    @(negedge clk); #1;
    chk("b_addr1", addr, 16'h0011);
    chk("b_under2", und, 1);
    @(negedge clk); #1;
    chk("b_under3", und, 1);
    chk("b_nvalid3", pv, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("b_valid", pv, 1);
      chk("b_data", pdata, 8'h10 + 8'(i));
      chk("b_sof", psof, (i == 0));
      chk("b_eol", peol, (i == 3 || i == 7));
      chk("b_under0", und, 0);
      chk("b_addr", addr, (i < 4) ? 16'h0013 + 16'(i) : 16'h0017);
    end
    @(negedge clk); #1;
    chk("b_end_busy", busy, 0);
    chk("b_end_valid", pv, 0);
    chk("b_end_under", und, 0);
    chk("b_end_addr", addr, 16'h0017);
    @(negedge clk); #1;
    chk("done_under", und, 0);

    // Backpressure: eight issues then hold with the first byte parked at the head.
    @(negedge clk); fs = 1'b1; rdy = 1'b0; #1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); fs = 1'b0; #1;
      chk("bp_addr", addr, 16'h0010 + 16'(k));
      chk("bp_under", und, 0);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("bp_valid", pv, 1);
    chk("bp_data", pdata, 8'h10);
    chk("bp_sof", psof, 1);
    chk("bp_busy", busy, 1);
    chk("bp_hold_addr", addr, 16'h0017);
    repeat (3) @(negedge clk);
    #1;
    chk("bp_stable_data", pdata, 8'h10);
    chk("bp_stable_addr", addr, 16'h0017);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rdy = 1'b1; #1;
      chk("bp_drain_valid", pv, 1);
      chk("bp_drain_data", pdata, 8'h10 + 8'(i));
      chk("bp_drain_eol", peol, (i == 3 || i == 7));
    end
    @(negedge clk); #1;
    chk("bp_empty", pv, 0);
    chk("bp_idle_busy", busy, 0);

    // Restart after five bytes consumed.
    @(negedge clk); fs = 1'b1; #1;
    repeat (3) begin
      @(negedge clk); fs = 1'b0; #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("rs_old_data", pdata, 8'h10 + 8'(i));
    end
    @(negedge clk); fs = 1'b1; rdy = 1'b0; #1;
    chk("rs_head15", pdata, 8'h15);
    @(negedge clk); fs = 1'b0; rdy = 1'b1; #1;
    chk("rs_flushed", pv, 0);
    chk("rs_addr", addr, 16'h0010);
    chk("rs_under", und, 1);
    repeat (2) begin
      @(negedge clk); #1;
      chk("rs_no_stale", pv, 0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("rs_valid", pv, 1);
      chk("rs_data", pdata, 8'h10 + 8'(i));
      chk("rs_sof", psof, (i == 0));
      chk("rs_eol", peol, (i == 3 || i == 7));
    end
    @(negedge clk); #1;
    chk("rs_end_valid", pv, 0);

    // Address wrap on the second instance.
    @(negedge clk); fs_w = 1'b1; rdy_w = 1'b1; #1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk); fs_w = 1'b0; #1;
      a = 16'hFFFE + 16'(j);
      chk("w_addr", addr_w, (j < 4) ? a : 16'h0001);
      if (j < 3) begin
        chk("w_nvalid", pv_w, 0);
      end else begin
        a = 16'hFFFE + 16'(j - 3);
        chk("w_valid", pv_w, 1);
        chk("w_data", pdata_w, a[7:0]);
        chk("w_sof", psof_w, (j == 3));
        chk("w_eol", peol_w, (j == 6));
      end
    end
    @(negedge clk); #1;
    chk("w_busy", busy_w, 0);

    // Reset mid-frame with bytes buffered; reset beats a simultaneous frame_start.
    @(negedge clk); fs = 1'b1; rdy = 1'b0; #1;
    repeat (4) begin
      @(negedge clk); fs = 1'b0; #1;
    end
    @(negedge clk); #1;
    chk("rr_pre_valid", pv, 1);
    chk("rr_pre_data", pdata, 8'h10);
    reset = 1'b1; fs = 1'b1;
    @(negedge clk); reset = 1'b0; fs = 1'b0; rdy = 1'b1; #1;
    chk("rr_valid", pv, 0);
    chk("rr_data", pdata, 8'h00);
    chk("rr_sof", psof, 0);
    chk("rr_eol", peol, 0);
    chk("rr_busy", busy, 0);
    chk("rr_under", und, 0);
    chk("rr_addr", addr, 16'h0010);
    repeat (4) @(negedge clk);
    #1;
    chk("rr_hold_valid", pv, 0);
    chk("rr_hold_addr", addr, 16'h0010);
    chk("rr_hold_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
